// File: rtl/rtc_control_salida_pkg.sv
// Shared definitions for the RTC bus-cycle generator: state encoding,
// default phase lengths and the phase-counter sizing helper.
package rtc_control_salida_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AHOLD,
        ST_DATA,
        ST_DHOLD,
        ST_DONE
    } state_t;

    localparam int unsigned T_ADDR_DEF = 4;
    localparam int unsigned T_DATA_DEF = 4;

    // A phase of length T is counted from T-1 down to 0; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rtc_control_salida.sv
// Bus-cycle generator for a parallel RTC with multiplexed AD bus:
// one address phase then one data phase per request, ending in a final pulse.
module rtc_control_salida
    import rtc_control_salida_pkg::*;
#(
    parameter int unsigned T_ADDR = T_ADDR_DEF,
    parameter int unsigned T_DATA = T_DATA_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_iniciar,
    input  logic       i_escribe,
    input  logic [7:0] i_direccion,
    input  logic [7:0] i_dato,
    input  logic       i_esc,
    output logic [7:0] o_data_out,
    output logic       o_cs,
    output logic       o_ad,
    output logic       o_rd,
    output logic       o_wr,
    output logic       o_final,
    output logic       o_escreg
);

    localparam int unsigned CW = cnt_width(T_ADDR, T_DATA);
    localparam logic [CW-1:0] ADDR_LOAD = CW'(T_ADDR - 1);
    localparam logic [CW-1:0] DATA_LOAD = CW'(T_DATA - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_escribe;
    logic [7:0]    r_dato;
    logic [7:0]    r_data_out;
    logic          r_cs;
    logic          r_ad;
    logic          r_rd;
    logic          r_wr;
    logic          r_final;
    logic          r_escreg;

    // Outputs are assigned for the state being entered, so they are valid
    // during that state; the address stays parked in r_data_out until DATA.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_escribe  <= 1'b0;
            r_dato     <= '0;
            r_data_out <= '0;
            r_cs       <= 1'b1;
            r_ad       <= 1'b1;
            r_rd       <= 1'b1;
            r_wr       <= 1'b1;
            r_final    <= 1'b0;
            r_escreg   <= 1'b0;
        end else begin
            r_final  <= 1'b0;
            r_escreg <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cs       <= 1'b1;
                    r_ad       <= 1'b1;
                    r_rd       <= 1'b1;
                    r_wr       <= 1'b1;
                    r_data_out <= '0;
                    if (i_iniciar) begin
                        r_escribe  <= i_escribe;
                        r_dato     <= i_dato;
                        r_state    <= ST_ADDR;
                        r_cnt      <= ADDR_LOAD;
                        r_cs       <= 1'b0;
                        r_ad       <= 1'b0;
                        r_wr       <= 1'b0;
                        r_data_out <= i_direccion;
                        r_escreg   <= i_esc;
                    end
                end
                ST_ADDR: begin
                    r_escreg <= i_esc;
                    if (r_cnt == '0) begin
                        r_state <= ST_AHOLD;
                        r_wr    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_AHOLD: begin
                    r_state <= ST_DATA;
                    r_cnt   <= DATA_LOAD;
                    r_ad    <= 1'b1;
                    if (r_escribe) begin
                        r_wr       <= 1'b0;
                        r_data_out <= r_dato;
                        r_escreg   <= i_esc;
                    end else begin
                        r_rd       <= 1'b0;
                        r_data_out <= '0;
                    end
                end
                ST_DATA: begin
                    r_escreg <= i_esc & r_escribe;
                    if (r_cnt == '0) begin
                        r_state <= ST_DHOLD;
                        r_rd    <= 1'b1;
                        r_wr    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DHOLD: begin
                    r_state    <= ST_DONE;
                    r_cs       <= 1'b1;
                    r_ad       <= 1'b1;
                    r_rd       <= 1'b1;
                    r_wr       <= 1'b1;
                    r_data_out <= '0;
                    r_final    <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data_out = r_data_out;
    assign o_cs       = r_cs;
    assign o_ad       = r_ad;
    assign o_rd       = r_rd;
    assign o_wr       = r_wr;
    assign o_final    = r_final;
    assign o_escreg   = r_escreg;

endmodule

// File: tb/tb_rtc_control_salida.sv
// Randomized scoreboard bench for rtc_control_salida: a transaction-position
// reference model predicts the pin vector after every clock edge.
module tb_rtc_control_salida;

    localparam int unsigned TA  = 4;
    localparam int unsigned TD  = 4;
    localparam int          LEN = TA + TD + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       escribe = 1'b0;
    logic [7:0] direccion = '0;
    logic [7:0] dato = '0;
    logic       esc = 1'b0;
    logic [7:0] data_out;
    logic       cs, ad, rd, wr, fin, escreg;

    rtc_control_salida #(.T_ADDR(TA), .T_DATA(TD)) dut (
        .i_clk(clk), .i_reset(reset), .i_iniciar(iniciar), .i_escribe(escribe),
        .i_direccion(direccion), .i_dato(dato), .i_esc(esc),
        .o_data_out(data_out), .o_cs(cs), .o_ad(ad), .o_rd(rd), .o_wr(wr),
        .o_final(fin), .o_escreg(escreg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];

    // Model: busy flag plus position within the transaction, counted in clocks.
    bit         m_busy = 0;
    int         m_p = 0;
    bit         m_wr = 0;
    logic [7:0] m_addr = '0;
    logic [7:0] m_dat = '0;

    function automatic logic [13:0] pins(input bit c, input bit a, input bit r, input bit w,
                                         input bit f, input bit e, input logic [7:0] d);
        return {c, a, r, w, f, e, d};
    endfunction

    function automatic logic [13:0] trace(input int p, input bit e);
        if (p < TA)             return pins(0, 0, 1, 0, 0, e, m_addr);
        else if (p == TA)       return pins(0, 0, 1, 1, 0, e, m_addr);
        else if (p <= TA + TD)  return m_wr ? pins(0, 1, 1, 0, 0, e, m_dat)
                                            : pins(0, 1, 0, 1, 0, 0, 8'h00);
        else if (p == TA+TD+1)  return pins(0, 1, 1, 1, 0, e & m_wr, m_wr ? m_dat : 8'h00);
        else                    return pins(1, 1, 1, 1, 1, 0, 8'h00);
    endfunction

    task automatic step(input bit r, input bit ini, input bit wrt,
                        input logic [7:0] dir, input logic [7:0] dat, input bit e);
        logic [13:0] ev;
        reset = r; iniciar = ini; escribe = wrt; direccion = dir; dato = dat; esc = e;
        if (r) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_p++;
            if (m_p == LEN) m_busy = 0;
        end else if (ini) begin
            m_busy = 1; m_p = 0; m_wr = wrt; m_addr = dir; m_dat = dat;
        end
        ev = (m_busy && !r) ? trace(m_p, e) : pins(1, 1, 1, 1, 0, 0, 8'h00);
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [13:0] act, ev;
        if (exp_q.size() > 0) begin
            ev  = exp_q.pop_front();
            act = {cs, ad, rd, wr, fin, escreg, data_out};
            n_cmp++;
            if (act !== ev) begin
                n_err++;
                $display("FAIL pins t=%0t got cs/ad/rd/wr/fin/oe/data=%b required %b", $time, act, ev);
            end
            n_cmp++;
            if ((rd === 1'b0 && wr === 1'b0) || (cs === 1'b1 && (rd === 1'b0 || wr === 1'b0))) begin
                n_err++;
                $display("FAIL strobes t=%0t got cs=%b rd=%b wr=%b required exclusive strobes under cs=0", $time, cs, rd, wr);
            end
        end
    end

    initial begin
        step(1, 0, 0, 8'h00, 8'h00, 1);
        step(1, 1, 1, 8'h33, 8'h44, 1);
        step(0, 0, 0, 8'h00, 8'h00, 1);
        // Read from FF
        step(0, 1, 0, 8'hFF, 8'h00, 1);
        repeat (13) step(0, 0, 0, 8'h00, 8'h00, 1);
        // Write 5A to 21, inputs scrambled mid-transaction
        step(0, 1, 1, 8'h21, 8'h5A, 1);
        for (int i = 0; i < 12; i++)
            step(0, 0, 1'($urandom), 8'($urandom), 8'($urandom), 1);
        // esc dropped during ADDR of a write
        step(0, 1, 1, 8'hA5, 8'h3C, 1);
        step(0, 0, 1, 8'hA5, 8'h3C, 0);
        repeat (12) step(0, 0, 1, 8'hA5, 8'h3C, 1);
        // Abort during DATA, then a fresh cycle
        step(0, 1, 1, 8'h10, 8'hC3, 1);
        repeat (6) step(0, 0, 0, 8'h00, 8'h00, 1);
        step(1, 0, 0, 8'h00, 8'h00, 1);
        step(0, 1, 0, 8'h42, 8'h00, 1);
        repeat (13) step(0, 0, 0, 8'h00, 8'h00, 1);
        // Continuous request
        repeat (50) step(0, 1, 1, 8'h77, 8'h88, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0));
        step(0, 0, 0, 8'h00, 8'h00, 1);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
